// File: rtl/mips_alu_pkg.sv
// Shared ALU operation codes and execute-stage FSM encodings.
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/mips_seq_multiplier.sv
// Iterative shift-add multiplier: low WIDTH bits of a*b after exactly WIDTH busy cycles.
module mips_seq_multiplier
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_abort,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    alu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // done is valid on the edge that performs the final iteration; product is that sum
    assign o_busy    = (r_state == MUL);
    assign o_done    = o_busy & w_last;
    assign o_product = w_acc_next;

    // Iteration state: latch operands on start, one add/shift step per cycle, no early exit
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state  <= MUL;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= i_a;
                        r_mplier <= i_b;
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt plus an iterative multiplier.
module mips_alu_exec
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Valid_In,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       Alu_Control,
    input  logic             Flush,
    output logic             Ready_Out,
    output logic             Valid_Out,
    output logic [WIDTH-1:0] Alu_Result,
    output logic             Zero,
    output logic             Overflow
);

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic             w_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;
    logic             w_accept;
    logic             w_start;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_op_result;
    logic             w_op_ovf;

    assign Ready_Out = ~w_busy;
    // Flush blocks the same-cycle accept
    assign w_accept  = Valid_In & Ready_Out & ~Flush;
    assign w_start   = w_accept & (Alu_Control == ALU_MUL);

    mips_seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_abort   (Flush),
        .i_start   (w_start),
        .i_a       (SrcA),
        .i_b       (SrcB),
        .o_busy    (w_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign w_sum  = SrcA + SrcB;
    assign w_diff = SrcA - SrcB;

    // Single-cycle datapath; unlisted codes (011, 111) fall through to ADD
    always_comb begin
        w_op_result = w_sum;
        w_op_ovf    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
        case (Alu_Control)
            ALU_AND: begin
                w_op_result = SrcA & SrcB;
                w_op_ovf    = 1'b0;
            end
            ALU_OR: begin
                w_op_result = SrcA | SrcB;
                w_op_ovf    = 1'b0;
            end
            ALU_SUB: begin
                w_op_result = w_diff;
                w_op_ovf    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
            end
            ALU_SLT: begin
                w_op_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
                w_op_ovf    = 1'b0;
            end
            default: ;
        endcase
    end

    // Result register and completion pulse; flush suppresses a same-edge multiply completion
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (Flush) begin
            r_valid <= 1'b0;
        end else if (w_mul_done) begin
            r_valid  <= 1'b1;
            r_result <= w_product;
            r_zero   <= (w_product == '0);
            r_ovf    <= 1'b0;
        end else if (w_accept && !w_start) begin
            r_valid  <= 1'b1;
            r_result <= w_op_result;
            r_zero   <= (w_op_result == '0);
            r_ovf    <= w_op_ovf;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign Valid_Out  = r_valid;
    assign Alu_Result = r_result;
    assign Zero       = r_zero;
    assign Overflow   = r_ovf;

endmodule
